mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares the single data-side port of the word-addressed, one-cycle-read-latency main memory between the instruction-fetch requester and the load/store requester. Arbitrates with round-robin on ties, sequences reads, and performs full-mask writes directly and partial-mask writes as read-modify-write. Sits between the core's fetch/memory stages and the memory array, replacing direct core-to-memory wiring.

## Interface
- WORD_LEN, 32, data and mask width
- ADDR_LEN, 32, address width
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- i_req_valid  in  1  fetch request pending
- i_req_ready  out  1  fetch request accepted this cycle when high with valid
- i_addr  in  ADDR_LEN  fetch byte address; held stable while valid
- i_resp_valid  out  1  one-cycle pulse, i_rdata valid
- i_rdata  out  WORD_LEN  fetched word
- d_req_valid  in  1  load/store request pending
- d_req_ready  out  1  load/store accepted this cycle when high with valid
- d_addr  in  ADDR_LEN  data byte address
- d_wen  in  1  1 = store, 0 = load
- d_wmask  in  WORD_LEN  bit-granular write mask
- d_wdata  in  WORD_LEN  store data
- d_resp_valid  out  1  one-cycle pulse, access complete
- d_rdata  out  WORD_LEN  load data; 0 on store responses
- mem_addr  out  ADDR_LEN  memory address, byte address passed unchanged
- mem_ren  out  1  read strobe; mem_rdata valid the following cycle
- mem_rdata  in  WORD_LEN  memory read data
- mem_wen  out  1  write strobe; word written at this rising edge
- mem_wdata  out  WORD_LEN  full word to write

## Operation
- States: IDLE, RD_ADDR, RD_DATA, WR.
- IDLE: i_req_ready/d_req_ready high only here, and only toward the granted requester. Only one valid → grant it. Both valid → grant the one not granted last (last_grant register). Accepted request (addr, wen, wmask, wdata, owner) is latched.
- Next state from IDLE: load or fetch → RD_ADDR; store with wmask == all-ones → WR; store with wmask == 0 → WR with mem_wen held 0 (no-op, still responds); any other store → RD_ADDR.
- RD_ADDR: mem_addr = latched addr, mem_ren = 1 → RD_DATA.
- RD_DATA, read: owner's resp_valid = 1, rdata = mem_rdata (pass-through) → IDLE.
- RD_DATA, partial store: merged = (mem_rdata & ~wmask) | (wdata & wmask) registered → WR. No byte swapping; mask and data in memory lane order.
- WR: mem_addr = latched addr, mem_wen = 1, mem_wdata = wdata (full mask) or merged; d_resp_valid = 1, d_rdata = 0 → IDLE.
- Fetch is never a write; i_* request has no wen.
- Responses have no ready; requesters must consume on the pulse.
- Non-owner's resp_valid always 0. mem_ren and mem_wen never both high.

## Timing
- Accept at cycle T (valid & ready in IDLE).
- Load/fetch: mem_ren at T+1, resp_valid at T+2, IDLE at T+3 (next accept at T+3).
- Full-mask or zero-mask store: WR/resp at T+1, next accept at T+2.
- Partial store: mem_ren T+1, merge registered T+2, mem_wen + resp at T+3, next accept at T+4.
- Reset: state IDLE, last_grant = fetch (data wins the first tie), all outputs 0 (ready, resp_valid, mem_ren, mem_wen, rdata, mem_addr, mem_wdata). In-flight transaction dropped, no response; a partial write not yet in WR never reaches memory.
- Request arriving while busy waits; ready stays 0 until IDLE.
- A requester whose request is still valid after its response re-arbitrates normally in IDLE.

## Structure
- Package mem_arb_pkg: state enum (IDLE, RD_ADDR, RD_DATA, WR), owner encoding (OWN_I, OWN_D), FULL_MASK constant, WORD_LEN/ADDR_LEN defaults.
- Single module; the merge is one expression and round-robin is one flag, so no sub-module.

## Test plan
- Fetch only, addr 0x100, memory word 0xDEADBEEF → i_req_ready at T, mem_ren T+1, i_resp_valid with 0xDEADBEEF at T+2, d_resp_valid stays 0.
- Full-mask store addr 0x2000, wdata 0x12345678 → mem_wen + d_resp_valid at T+1, mem_wdata 0x12345678, no mem_ren, then load of 0x2000 returns 0x12345678.
- Partial store, old 0xAABBCCDD, wmask 0x000000FF, wdata 0x00000011 → mem_ren T+1, mem_wen T+3 with 0xAABBCC11.
- Both valid continuously after reset → grants D, I, D, I in order; each response on the correct port only.
- Zero-mask store → d_resp_valid at T+1, mem_wen 0, memory unchanged.
- rst asserted at T+2 of a partial store → no mem_wen, no d_resp_valid, all outputs 0 next cycle, next tie grants data.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the fetch/load-store memory arbiter
package mem_arb_pkg;
    localparam int WORD_LEN = 32;
    localparam int ADDR_LEN = 32;
    localparam logic [WORD_LEN-1:0] FULL_MASK = '1;
    typedef enum logic [1:0] {IDLE, RD_ADDR, RD_DATA, WR} state_t;
    typedef enum logic {OWN_I, OWN_D} owner_t;
endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin sharing of one memory port between fetch and load/store,
// with read-modify-write for partial-mask stores
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WORD_LEN = mem_arb_pkg::WORD_LEN,
    parameter int ADDR_LEN = mem_arb_pkg::ADDR_LEN
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_req_valid,
    output logic                i_req_ready,
    input  logic [ADDR_LEN-1:0] i_addr,
    output logic                i_resp_valid,
    output logic [WORD_LEN-1:0] i_rdata,
    input  logic                d_req_valid,
    output logic                d_req_ready,
    input  logic [ADDR_LEN-1:0] d_addr,
    input  logic                d_wen,
    input  logic [WORD_LEN-1:0] d_wmask,
    input  logic [WORD_LEN-1:0] d_wdata,
    output logic                d_resp_valid,
    output logic [WORD_LEN-1:0] d_rdata,
    output logic [ADDR_LEN-1:0] mem_addr,
    output logic                mem_ren,
    input  logic [WORD_LEN-1:0] mem_rdata,
    output logic                mem_wen,
    output logic [WORD_LEN-1:0] mem_wdata
);
    state_t              state, state_n;
    owner_t              last_grant, owner_q;
    logic [ADDR_LEN-1:0] addr_q;
    logic                wen_q;
    logic [WORD_LEN-1:0] wmask_q, data_q;
    logic                gnt_i, gnt_d, accept;

    // On a tie the requester that did not win last time is served
    assign gnt_d  = d_req_valid && (!i_req_valid || last_grant == OWN_I);
    assign gnt_i  = i_req_valid && !gnt_d;
    assign accept = state == IDLE && (gnt_i || gnt_d);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= OWN_I;
            owner_q    <= OWN_I;
            addr_q     <= '0;
            wen_q      <= 1'b0;
            wmask_q    <= '0;
            data_q     <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                last_grant <= gnt_d ? OWN_D : OWN_I;
                owner_q    <= gnt_d ? OWN_D : OWN_I;
                addr_q     <= gnt_d ? d_addr : i_addr;
                wen_q      <= gnt_d && d_wen;
                wmask_q    <= d_wmask;
                data_q     <= d_wdata;
            end else if (state == RD_DATA && wen_q) begin
                // store data is replaced by the merged word for the write-back
                data_q <= (mem_rdata & ~wmask_q) | (data_q & wmask_q);
            end
        end
    end

    always_comb begin
        state_n      = state;
        i_req_ready  = 1'b0;
        d_req_ready  = 1'b0;
        i_resp_valid = 1'b0;
        d_resp_valid = 1'b0;
        i_rdata      = '0;
        d_rdata      = '0;
        mem_addr     = '0;
        mem_ren      = 1'b0;
        mem_wen      = 1'b0;
        mem_wdata    = '0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    i_req_ready = gnt_i;
                    d_req_ready = gnt_d;
                    if (gnt_d && d_wen)
                        state_n = (&d_wmask || ~|d_wmask) ? WR : RD_ADDR;
                    else if (accept)
                        state_n = RD_ADDR;
                end
                RD_ADDR: begin
                    mem_addr = addr_q;
                    mem_ren  = 1'b1;
                    state_n  = RD_DATA;
                end
                RD_DATA: begin
                    i_resp_valid = !wen_q && owner_q == OWN_I;
                    d_resp_valid = !wen_q && owner_q == OWN_D;
                    i_rdata      = i_resp_valid ? mem_rdata : '0;
                    d_rdata      = d_resp_valid ? mem_rdata : '0;
                    state_n      = wen_q ? WR : IDLE;
                end
                WR: begin
                    // an all-zero mask still responds but leaves memory untouched
                    mem_addr     = addr_q;
                    mem_wen      = |wmask_q;
                    mem_wdata    = data_q;
                    d_resp_valid = 1'b1;
                    state_n      = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed table-driven bench for mem_arbiter with a one-cycle-latency memory model
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic        clk, rst;
    logic        i_req_valid, i_req_ready, i_resp_valid;
    logic [31:0] i_addr, i_rdata;
    logic        d_req_valid, d_req_ready, d_wen, d_resp_valid;
    logic [31:0] d_addr, d_wmask, d_wdata, d_rdata;
    logic [31:0] mem_addr, mem_rdata, mem_wdata;
    logic        mem_ren, mem_wen;
    logic        pre_en;
    logic [31:0] pre_addr, pre_data;
    logic [31:0] mem [0:4095];
    int          n_chk = 0, n_fail = 0;

    typedef struct {
        logic        is_d;
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wmask, wdata;
        logic        pre;
        logic [31:0] pre_data, exp_rdata, exp_mem;
        int          lat;
        logic        exp_wen;
    } vec_t;
    vec_t tbl [8];

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_addr(i_addr),
        .i_resp_valid(i_resp_valid), .i_rdata(i_rdata),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_addr(d_addr),
        .d_wen(d_wen), .d_wmask(d_wmask), .d_wdata(d_wdata),
        .d_resp_valid(d_resp_valid), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_ren(mem_ren), .mem_rdata(mem_rdata),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_ren) mem_rdata <= mem[mem_addr[13:2]];
        if (mem_wen) mem[mem_addr[13:2]] <= mem_wdata;
        if (pre_en) mem[pre_addr[13:2]] <= pre_data;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        pre_en = 1'b1; pre_addr = a; pre_data = d;
        @(posedge clk); #1;
        pre_en = 1'b0;
    endtask

    task automatic run_vec(input int k, input vec_t v);
        logic last;
        if (v.pre) preload(v.addr, v.pre_data);
        i_req_valid = !v.is_d; d_req_valid = v.is_d;
        i_addr = v.addr; d_addr = v.addr; d_wen = v.wen; d_wmask = v.wmask; d_wdata = v.wdata;
        @(negedge clk);
        check($sformatf("v%0d_ready", k), {i_req_ready, d_req_ready}, v.is_d ? 2'b01 : 2'b10);
        @(posedge clk); #1;
        i_req_valid = 1'b0; d_req_valid = 1'b0;
        for (int c = 1; c <= v.lat; c++) begin
            @(negedge clk);
            last = (c == v.lat);
            check($sformatf("v%0d_c%0d_ren", k, c), mem_ren, c == 1 && v.lat > 1);
            check($sformatf("v%0d_c%0d_wen", k, c), mem_wen, last && v.exp_wen);
            check($sformatf("v%0d_c%0d_resp", k, c), {i_resp_valid, d_resp_valid},
                  !last ? 2'b00 : (v.is_d ? 2'b01 : 2'b10));
            if (c == 1 && v.lat > 1) check($sformatf("v%0d_raddr", k), mem_addr, v.addr);
            if (last) begin
                check($sformatf("v%0d_rdata", k), v.is_d ? d_rdata : i_rdata, v.exp_rdata);
                if (v.exp_wen) begin
                    check($sformatf("v%0d_waddr", k), mem_addr, v.addr);
                    check($sformatf("v%0d_wdata", k), mem_wdata, v.exp_mem);
                end
            end
        end
        @(posedge clk); #1;
        check($sformatf("v%0d_mem", k), mem[v.addr[13:2]], v.exp_mem);
    endtask

    initial begin
        int n_g, n_r;
        tbl[0] = '{1'b0, 32'h100,  1'b0, 32'h0,       32'h0,        1'b1, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 2, 1'b0};
        tbl[1] = '{1'b1, 32'h2000, 1'b1, FULL_MASK,   32'h12345678, 1'b1, 32'h0,        32'h0,        32'h12345678, 1, 1'b1};
        tbl[2] = '{1'b1, 32'h2000, 1'b0, 32'h0,       32'h0,        1'b0, 32'h0,        32'h12345678, 32'h12345678, 2, 1'b0};
        tbl[3] = '{1'b1, 32'h300,  1'b1, 32'h000000FF, 32'h00000011, 1'b1, 32'hAABBCCDD, 32'h0,        32'hAABBCC11, 3, 1'b1};
        tbl[4] = '{1'b1, 32'h400,  1'b1, 32'h0,       32'hFFFFFFFF, 1'b1, 32'h55555555, 32'h0,        32'h55555555, 1, 1'b0};
        tbl[5] = '{1'b1, 32'h500,  1'b1, 32'h0F0F0000, 32'h12345678, 1'b1, 32'hF0F0F0F0, 32'h0,        32'hF2F4F0F0, 3, 1'b1};
        tbl[6] = '{1'b0, 32'h500,  1'b0, 32'h0,       32'h0,        1'b0, 32'h0,        32'hF2F4F0F0, 32'hF2F4F0F0, 2, 1'b0};
        tbl[7] = '{1'b1, 32'h600,  1'b0, FULL_MASK,   32'hCAFEF00D, 1'b1, 32'h0BADF00D, 32'h0BADF00D, 32'h0BADF00D, 2, 1'b0};

        rst = 1'b1; pre_en = 1'b0; pre_addr = '0; pre_data = '0;
        i_req_valid = 1'b0; i_addr = '0; d_req_valid = 1'b0; d_addr = '0;
        d_wen = 1'b0; d_wmask = '0; d_wdata = '0;
        @(posedge clk); #1;
        preload(32'h100, 32'hDEADBEEF);
        preload(32'h2000, 32'h12345678);
        @(negedge clk);
        check("rst_ctl", {i_req_ready, d_req_ready, i_resp_valid, d_resp_valid, mem_ren, mem_wen}, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_rdata", i_rdata | d_rdata, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // both requesters valid continuously: expect D, I, D, I every three cycles
        n_g = 0; n_r = 0;
        i_addr = 32'h100; d_addr = 32'h2000; d_wen = 1'b0;
        i_req_valid = 1'b1; d_req_valid = 1'b1;
        for (int c = 0; c < 30 && n_r < 4; c++) begin
            @(negedge clk);
            if (i_req_ready || d_req_ready) begin
                check($sformatf("rr_grant%0d", n_g), {i_req_ready, d_req_ready}, n_g % 2 ? 2'b10 : 2'b01);
                check($sformatf("rr_grant%0d_cycle", n_g), c, 3 * n_g);
                n_g++;
            end
            if (i_resp_valid || d_resp_valid) begin
                check($sformatf("rr_resp%0d", n_r), {i_resp_valid, d_resp_valid}, n_r % 2 ? 2'b10 : 2'b01);
                check($sformatf("rr_rdata%0d", n_r), i_resp_valid ? i_rdata : d_rdata,
                      n_r % 2 ? 32'hDEADBEEF : 32'h12345678);
                n_r++;
            end
            @(posedge clk); #1;
            if (n_g == 4) begin i_req_valid = 1'b0; d_req_valid = 1'b0; end
        end
        check("rr_grants", n_g, 4);
        check("rr_resps", n_r, 4);
        i_req_valid = 1'b0; d_req_valid = 1'b0;
        @(posedge clk); #1;

        for (int k = 0; k < 8; k++) run_vec(k, tbl[k]);

        // reset during the merge cycle of a partial store must drop it
        d_req_valid = 1'b1; d_addr = 32'h300; d_wen = 1'b1; d_wmask = 32'h0000FF00; d_wdata = 32'h00007700;
        @(negedge clk);
        check("prst_ready", d_req_ready, 1);
        @(posedge clk); #1;
        d_req_valid = 1'b0;
        @(negedge clk);
        check("prst_ren", mem_ren, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("prst_in_rst", {i_req_ready, d_req_ready, i_resp_valid, d_resp_valid, mem_ren, mem_wen}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check($sformatf("prst_quiet%0d", c),
                  {i_req_ready, d_req_ready, i_resp_valid, d_resp_valid, mem_ren, mem_wen}, 0);
            check($sformatf("prst_addr%0d", c), mem_addr | mem_wdata, 0);
        end
        @(posedge clk); #1;
        check("prst_mem", mem[12'h300 >> 2], 32'hAABBCC11);

        i_addr = 32'h100; i_req_valid = 1'b1;
        d_addr = 32'h2000; d_wen = 1'b0; d_req_valid = 1'b1;
        @(negedge clk);
        check("prst_tie", {i_req_ready, d_req_ready}, 2'b01);
        @(posedge clk); #1;
        i_req_valid = 1'b0; d_req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("prst_tie_resp", {i_resp_valid, d_resp_valid}, 2'b01);
        check("prst_tie_rdata", d_rdata, 32'h12345678);
        @(posedge clk); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
